// File: rtl/sdiomux_dir_ctrl.sv
// Direction controller and arbiter for a bank of bidirectional SDIOMUX pads.
// Grants the pin group to a transmit or receive burst and sequences break-before-make turnaround.
`timescale 1ns/1ps

module sdiomux_dir_ctrl #(
  parameter int WIDTH       = 4,
  parameter int LEN_W       = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tx_req,
  input  logic [LEN_W-1:0] i_tx_len,
  input  logic             i_tx_valid,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_tx_ready,
  output logic             o_tx_done,
  input  logic             i_rx_req,
  input  logic [LEN_W-1:0] i_rx_len,
  output logic             o_rx_valid,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_done,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_pad_o_dat,
  output logic [WIDTH-1:0] o_pad_o_en,
  output logic [WIDTH-1:0] o_pad_i_en,
  input  logic [WIDTH-1:0] i_pad_i_dat
);

  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TURN_OUT  = 3'd1,
    S_TX_DRIVE  = 3'd2,
    S_TX_LAST   = 3'd3,
    S_TURN_IN   = 3'd4,
    S_RX_SAMPLE = 3'd5
  } state_t;

  state_t             r_state;
  logic [TURN_W-1:0]  r_turn_cnt;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [LEN_W-1:0]   r_len;
  logic               r_last_rx;
  logic               r_tx_ready;
  logic               r_tx_done;
  logic               r_rx_valid;
  logic               r_rx_done;
  logic [WIDTH-1:0]   r_rx_data;
  logic               r_busy;
  logic [WIDTH-1:0]   r_pad_o_dat;
  logic               r_o_en_n;
  logic               r_i_en_n;

  logic               w_grant_tx;
  logic               w_grant_rx;
  logic               w_tx_accept;
  logic               w_turn_done;
  logic               w_beat_last;

  assign w_tx_accept = i_tx_valid & r_tx_ready;
  assign w_turn_done = (r_turn_cnt == TURN_LAST);
  assign w_beat_last = (r_beat_cnt == r_len);

  // Round-robin arbitration: on a tie the requester not served last wins.
  always_comb begin
    w_grant_tx = 1'b0;
    w_grant_rx = 1'b0;
    if (i_tx_req && i_rx_req) begin
      if (r_last_rx) begin
        w_grant_tx = 1'b1;
      end else begin
        w_grant_rx = 1'b1;
      end
    end else if (i_tx_req) begin
      w_grant_tx = 1'b1;
    end else if (i_rx_req) begin
      w_grant_rx = 1'b1;
    end else begin
      w_grant_tx = 1'b0;
      w_grant_rx = 1'b0;
    end
  end

  // Direction FSM with all pad and handshake outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_turn_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_len       <= '0;
      r_last_rx   <= 1'b1;
      r_tx_ready  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_done   <= 1'b0;
      r_rx_data   <= '0;
      r_busy      <= 1'b0;
      r_pad_o_dat <= '0;
      r_o_en_n    <= 1'b1;
      r_i_en_n    <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_tx) begin
            r_state    <= S_TURN_OUT;
            r_len      <= i_tx_len;
            r_last_rx  <= 1'b0;
            r_busy     <= 1'b1;
            r_i_en_n   <= 1'b1;
            r_turn_cnt <= '0;
            r_beat_cnt <= '0;
          end else if (w_grant_rx) begin
            r_state    <= S_RX_SAMPLE;
            r_len      <= i_rx_len;
            r_last_rx  <= 1'b1;
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
          end
        end
        S_TURN_OUT: begin
          if (w_turn_done) begin
            r_state    <= S_TX_DRIVE;
            r_tx_ready <= 1'b1;
          end else begin
            r_turn_cnt <= r_turn_cnt + TURN_W'(1);
          end
        end
        S_TX_DRIVE: begin
          // Output enable follows the first valid beat so the pads never drive stale data.
          if (w_tx_accept) begin
            r_pad_o_dat <= i_tx_data;
            r_o_en_n    <= 1'b0;
            if (w_beat_last) begin
              r_tx_ready <= 1'b0;
              r_state    <= S_TX_LAST;
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
        end
        S_TX_LAST: begin
          r_state     <= S_TURN_IN;
          r_o_en_n    <= 1'b1;
          r_pad_o_dat <= '0;
          r_turn_cnt  <= '0;
        end
        S_TURN_IN: begin
          if (w_turn_done) begin
            r_state   <= S_IDLE;
            r_i_en_n  <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b1;
          end else begin
            r_turn_cnt <= r_turn_cnt + TURN_W'(1);
          end
        end
        S_RX_SAMPLE: begin
          r_rx_data  <= i_pad_i_dat;
          r_rx_valid <= 1'b1;
          if (w_beat_last) begin
            r_rx_done <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_tx_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_pad_o_dat <= '0;
          r_o_en_n    <= 1'b1;
          r_i_en_n    <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready  = r_tx_ready;
  assign o_tx_done   = r_tx_done;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_data;
  assign o_rx_done   = r_rx_done;
  assign o_busy      = r_busy;
  assign o_pad_o_dat = r_pad_o_dat;
  assign o_pad_o_en  = {WIDTH{r_o_en_n}};
  assign o_pad_i_en  = {WIDTH{r_i_en_n}};

  sdiomux_dir_ctrl_chk #(.WIDTH(WIDTH)) u_chk (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pad_o_en (o_pad_o_en),
    .i_pad_i_en (o_pad_i_en),
    .i_tx_done  (o_tx_done),
    .i_rx_done  (o_rx_done),
    .i_busy     (o_busy)
  );

endmodule

// Property checks on the controller outputs; no logic, only assertions.
module sdiomux_dir_ctrl_chk #(
  parameter int WIDTH = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  input logic [WIDTH-1:0] i_pad_o_en,
  input logic [WIDTH-1:0] i_pad_i_en,
  input logic             i_tx_done,
  input logic             i_rx_done,
  input logic             i_busy
);

  a_no_overlap: assert property (@(posedge i_clk) disable iff (i_rst)
    &(i_pad_o_en | i_pad_i_en));

  a_done_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_tx_done && i_rx_done));

  a_done_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_tx_done || i_rx_done) |-> !i_busy);

endmodule

// File: tb/tb_sdiomux_dir_ctrl.sv
// Scoreboard bench for sdiomux_dir_ctrl: drivers push expected beats and bursts,
// a negedge monitor pops and compares against what the pads and handshakes show.
`timescale 1ns/1ps

module tb_sdiomux_dir_ctrl;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int TURN  = 2;
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             tx_req, tx_valid, tx_ready, tx_done;
  logic [LEN_W-1:0] tx_len, rx_len;
  logic [WIDTH-1:0] tx_data, rx_data, o_dat, o_en, i_en, pad_i_dat;
  logic             rx_req, rx_valid, rx_done, busy;

  always #5 clk = ~clk;

  sdiomux_dir_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TURN_CYCLES(TURN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_tx_req(tx_req), .i_tx_len(tx_len), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_ready(tx_ready), .o_tx_done(tx_done),
    .i_rx_req(rx_req), .i_rx_len(rx_len), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .o_rx_done(rx_done), .o_busy(busy),
    .o_pad_o_dat(o_dat), .o_pad_o_en(o_en), .o_pad_i_en(i_en), .i_pad_i_dat(pad_i_dat)
  );

  typedef struct { bit is_tx; int len; int drive; } burst_t;
  burst_t           burst_q[$];
  logic [WIDTH-1:0] tx_q[$];
  logic [WIDTH-1:0] rx_q[$];
  logic [WIDTH-1:0] beats[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en    = 1'b0;
  bit m_last_rx = 1'b1;
  bit rx_ramp   = 1'b0;
  int stall_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic gen_beats(input int len);
    logic [WIDTH-1:0] v, prev;
    prev = '0;
    beats.delete();
    for (int i = 0; i <= len; i++) begin
      do v = WIDTH'($urandom_range((1 << WIDTH) - 1, 1)); while (v == prev);
      beats.push_back(v);
      prev = v;
    end
  endtask

  // Called just after the grant edge; offers beats and notes which edges accepted them.
  task automatic tx_drive(input int len);
    int i, guard, first_e, last_e, gap;
    bit v, acc;
    i = 0; guard = 0; first_e = -1; last_e = -1; gap = 0;
    while (i <= len && guard < 3000) begin
      @(negedge clk);
      guard++;
      case (stall_mode)
        1:       v = ($urandom_range(3, 0) != 0);
        2:       v = (gap == 0);
        default: v = 1'b1;
      endcase
      if (gap > 0) gap--;
      tx_valid = v;
      tx_data  = beats[i];
      acc = v && tx_ready;
      @(posedge clk);
      if (acc) begin
        if (first_e < 0) first_e = guard;
        last_e = guard;
        tx_q.push_back(beats[i]);
        i++;
        if (stall_mode == 2) gap = 3;
      end
    end
    #1 tx_valid = 1'b0;
    check("tx_accepted", i, len + 1);
    // pads show every cycle from the first acceptance to the last, plus one final-beat cycle
    burst_q.push_back('{1'b1, len, last_e - first_e + 1});
  endtask

  task automatic rx_drive(input int len);
    logic [WIDTH-1:0] v;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      v = rx_ramp ? WIDTH'(i + 1) : WIDTH'($urandom);
      pad_i_dat = v;
      rx_q.push_back(v);
      @(posedge clk);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic run_burst(input bit treq, input bit rreq, input int tlen, input int rlen,
                           input bit keep, input bit given);
    bit win_tx;
    int g;
    check("idle_before_req", busy, 0);
    win_tx = treq && (!rreq || m_last_rx);
    m_last_rx = !win_tx;
    if (win_tx && !given) gen_beats(tlen);
    tx_req = treq; rx_req = rreq;
    tx_len = LEN_W'(tlen); rx_len = LEN_W'(rlen);
    @(posedge clk);
    #1;
    check("grant_busy", busy, 1);
    check("grant_dir_i_en", i_en, win_tx ? ALL1 : '0);
    if (!keep) begin tx_req = 1'b0; rx_req = 1'b0; end
    tx_len = LEN_W'($urandom);
    rx_len = LEN_W'($urandom);
    if (win_tx) tx_drive(tlen);
    else begin
      burst_q.push_back('{1'b0, rlen, 0});
      rx_drive(rlen);
    end
    g = 0;
    do begin @(negedge clk); g++; end while (busy && g < 50);
    check("burst_end_idle", busy, 0);
  endtask

  // Monitor
  int drive_cnt, beat_cnt, turnin_cnt, pre_cnt, rx_cnt;
  bit prev_drv, seen_drv;
  logic [WIDTH-1:0] prev_dat;
  burst_t b;

  initial begin
    drive_cnt = 0; beat_cnt = 0; turnin_cnt = 0; pre_cnt = 0; rx_cnt = 0;
    prev_drv = 1'b0; seen_drv = 1'b0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        drive_cnt = 0; beat_cnt = 0; turnin_cnt = 0; pre_cnt = 0; rx_cnt = 0;
        prev_drv = 1'b0; seen_drv = 1'b0;
      end else begin
        check("en_overlap", |(~o_en & ~i_en), 0);
        check("en_uniform", ((o_en == '0) || (o_en == ALL1)) && ((i_en == '0) || (i_en == ALL1)), 1);
        if (o_en == '0) begin
          drive_cnt++;
          if (!prev_drv || o_dat != prev_dat) begin
            if (tx_q.size() == 0) check("tx_beat_unexpected", 1, 0);
            else check("tx_beat", o_dat, tx_q.pop_front());
            beat_cnt++;
          end
          prev_dat = o_dat;
          seen_drv = 1'b1;
        end else if (i_en == ALL1) begin
          if (seen_drv) turnin_cnt++;
          else pre_cnt++;
        end
        prev_drv = (o_en == '0);
        if (tx_done) begin
          if (burst_q.size() == 0) check("tx_done_unexpected", 1, 0);
          else begin
            b = burst_q.pop_front();
            check("tx_done_kind", b.is_tx, 1);
            check("tx_beats", beat_cnt, b.len + 1);
            check("tx_drive_cycles", drive_cnt, b.drive);
            check("tx_turn_in", turnin_cnt, TURN);
            check("tx_turn_out_min", pre_cnt >= TURN + 1, 1);
            check("tx_done_i_en", i_en, 0);
            check("tx_done_o_en", o_en, ALL1);
            check("tx_done_ready", tx_ready, 0);
          end
          drive_cnt = 0; beat_cnt = 0; turnin_cnt = 0; pre_cnt = 0; seen_drv = 1'b0;
        end
        if (rx_valid) begin
          if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
          else check("rx_data", rx_data, rx_q.pop_front());
          check("rx_o_en", o_en, ALL1);
          rx_cnt++;
        end
        if (rx_done) begin
          if (burst_q.size() == 0) check("rx_done_unexpected", 1, 0);
          else begin
            b = burst_q.pop_front();
            check("rx_done_kind", b.is_tx, 0);
            check("rx_beats", rx_cnt, b.len + 1);
          end
          rx_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g, r;
    rst = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tx_len = '0; rx_len = '0; pad_i_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_en", o_en, ALL1);
    check("rst_i_en", i_en, 0);
    check("rst_o_dat", o_dat, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_flags", {tx_done, rx_valid, rx_done}, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a LEN=5 transmit burst.
    @(negedge clk);
    tx_req = 1'b1; tx_len = 8'd5;
    @(posedge clk);
    #1 tx_req = 1'b0;
    g = 0;
    while (!tx_ready && g < 20) begin @(negedge clk); g++; end
    check("ready_before_reset", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 4'h3;
    @(posedge clk);
    @(negedge clk);
    tx_data = 4'h4;
    check("driving_before_reset", o_en, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_o_en", o_en, ALL1);
    check("midrst_i_en", i_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tx_ready, 0);
    check("midrst_o_dat", o_dat, 0);
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    m_last_rx = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {busy, i_en, o_en}, {1'b0, {WIDTH{1'b0}}, ALL1});
    end
    mon_en = 1'b1;
    @(negedge clk);

    // Directed transmit burst A,5,C with continuous valid.
    stall_mode = 0;
    beats.delete();
    beats.push_back(4'hA); beats.push_back(4'h5); beats.push_back(4'hC);
    run_burst(1'b1, 1'b0, 2, 0, 1'b0, 1'b1);

    // Underrun: three idle cycles between the two beats.
    stall_mode = 2;
    run_burst(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);

    // Receive ramp 1..4.
    rx_ramp = 1'b1;
    run_burst(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    rx_ramp = 1'b0;

    // Both requests held: grants must alternate and idle lasts one cycle.
    stall_mode = 0;
    for (int k = 0; k < 4; k++)
      run_burst(1'b1, 1'b1, $urandom_range(6, 0), $urandom_range(6, 0), 1'b1, 1'b0);
    tx_req = 1'b0; rx_req = 1'b0;
    @(negedge clk);

    // Maximum length bursts.
    stall_mode = 1;
    run_burst(1'b1, 1'b0, 255, 0, 1'b0, 1'b0);
    run_burst(1'b0, 1'b1, 0, 255, 1'b0, 1'b0);

    // Random mix.
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(2, 0);
      stall_mode = $urandom_range(1, 0);
      run_burst(r != 1, r != 0, $urandom_range(15, 0), $urandom_range(15, 0), 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("tx_q_empty", tx_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);
    check("burst_q_empty", burst_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
